fifo_stream_reader: RTL and testbench

Read-side drain engine for the synchronous `fifo`. It pops words from the FIFO's first-word-fall-through read port (`empty`, `rd_data`, `rd_en`). It re-presents them as a registered valid/ready stream toward downstream consumers (e.g. the core's fetch/IO path). A 2-entry skid stage gives full throughput with no combinational path from `m_ready` to `fifo_rd_en`. The block also provides a synchronous flush and a delivered-word counter.

---
 rtl/fifo_pkg.sv | 14 +
 rtl/fifo_stream_reader.sv | 84 ++++++++
 tb/tb_fifo_stream_reader.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO-side types and sizes.
// Holds data width, FIFO depth and the stream reader state encoding.
package fifo_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int FIFO_DEPTH = 8;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } reader_state_e;

endpackage

// File: rtl/fifo_stream_reader.sv
// Drains a first-word-fall-through FIFO into a registered valid/ready stream.
// Ports: clk, rst_n (async low); FIFO read side fifo_empty/fifo_rd_data/
// fifo_rd_en; stream m_valid/m_data/m_ready; flush; word_count (handshakes).
module fifo_stream_reader #(
    parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    input  logic                  flush,
    output logic [CNT_WIDTH-1:0]  word_count
);

    import fifo_pkg::*;

    reader_state_e         state;
    logic [DATA_WIDTH-1:0] skid;
    logic                  fire;
    logic                  pop;

    assign fire = m_valid && m_ready;

    // Pop decision uses only local occupancy, never m_ready, so the
    // FIFO read strobe has no combinational path from the consumer.
    assign pop = rst_n && !fifo_empty && !flush && (state != TWO);

    assign fifo_rd_en = pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= EMPTY;
            m_valid    <= 1'b0;
            m_data     <= '0;
            skid       <= '0;
            word_count <= '0;
        end else begin
            if (fire) begin
                word_count <= word_count + CNT_WIDTH'(1);
            end
            if (flush) begin
                state   <= EMPTY;
                m_valid <= 1'b0;
            end else begin
                unique case (state)
                    EMPTY: begin
                        if (pop) begin
                            m_data  <= fifo_rd_data;
                            m_valid <= 1'b1;
                            state   <= ONE;
                        end
                    end
                    ONE: begin
                        if (pop && fire) begin
                            m_data <= fifo_rd_data;
                        end else if (pop) begin
                            skid  <= fifo_rd_data;
                            state <= TWO;
                        end else if (fire) begin
                            m_valid <= 1'b0;
                            state   <= EMPTY;
                        end
                    end
                    TWO: begin
                        if (fire) begin
                            m_data <= skid;
                            state  <= ONE;
                        end
                    end
                    default: begin
                        m_valid <= 1'b0;
                        state   <= EMPTY;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a behavioural FWFT FIFO.
// Ports of two instances (16-bit and 4-bit counters) share all inputs.
module tb_fifo_stream_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fifo_empty;
    logic [15:0] fifo_rd_data;
    logic        fifo_rd_en;
    logic        fifo_rd_en4;
    logic        m_valid;
    logic        m_valid4;
    logic [15:0] m_data;
    logic [15:0] m_data4;
    logic        m_ready;
    logic        flush;
    logic [15:0] word_count;
    logic [3:0]  word_count4;

    logic [15:0] mem [64];
    logic [5:0]  wp;
    logic [5:0]  rp;

    logic [15:0] exp_q [$];
    int          exp_cnt;
    int          checks;
    int          errors;

    always #5 clk = ~clk;

    assign fifo_empty   = (wp == rp);
    assign fifo_rd_data = mem[rp];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) rp <= '0;
        else if (fifo_rd_en) rp <= rp + 6'd1;
    end

    fifo_stream_reader #(.DATA_WIDTH(16), .CNT_WIDTH(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fifo_empty   (fifo_empty),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd_en   (fifo_rd_en),
        .m_valid      (m_valid),
        .m_data       (m_data),
        .m_ready      (m_ready),
        .flush        (flush),
        .word_count   (word_count)
    );

    fifo_stream_reader #(.DATA_WIDTH(16), .CNT_WIDTH(4)) dut4 (
        .clk          (clk),
        .rst_n        (rst_n),
        .fifo_empty   (fifo_empty),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd_en   (fifo_rd_en4),
        .m_valid      (m_valid4),
        .m_data       (m_data4),
        .m_ready      (m_ready),
        .flush        (flush),
        .word_count   (word_count4)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [15:0] d);
        mem[wp] = d;
        wp = wp + 6'd1;
        exp_q.push_back(d);
    endtask

    // One clock: score any handshake before the edge, then check counters.
    task automatic cyc();
        logic [15:0] e;
        if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_fire", {31'b0, m_valid}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("data", {16'b0, m_data}, {16'b0, e});
                chk("data4", {16'b0, m_data4}, {16'b0, e});
                exp_cnt++;
            end
        end
        @(posedge clk);
        #1;
        chk("cnt", {16'b0, word_count}, {16'b0, exp_cnt[15:0]});
        chk("cnt4", {28'b0, word_count4}, {28'b0, exp_cnt[3:0]});
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        wp = '0;
        exp_q.delete();
        exp_cnt = 0;
        repeat (n) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        m_ready = 1'b0;
        flush   = 1'b0;
        #1;

        // reset
        do_reset(5);
        chk("rst_valid", {31'b0, m_valid}, 32'd0);
        chk("rst_data", {16'b0, m_data}, 32'd0);
        chk("rst_cnt", {16'b0, word_count}, 32'd0);
        chk("rst_rden", {31'b0, fifo_rd_en}, 32'd0);

        // async reset between edges
        push(16'h5555);
        cyc();
        chk("pre_async_valid", {31'b0, m_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_valid", {31'b0, m_valid}, 32'd0);
        chk("async_data", {16'b0, m_data}, 32'd0);
        wp = '0;
        exp_q.delete();
        exp_cnt = 0;
        rst_n = 1'b1;
        cyc();

        // streaming
        m_ready = 1'b1;
        for (int i = 1; i <= 8; i++) push(16'(i * 16'h1111));
        cyc();
        for (int i = 0; i < 8; i++) begin
            chk("stream_valid", {31'b0, m_valid}, 32'd1);
            cyc();
        end
        chk("stream_cnt", {16'b0, word_count}, 32'd8);
        chk("stream_empty", {31'b0, fifo_empty}, 32'd1);
        chk("stream_idle", {31'b0, m_valid}, 32'd0);

        // backpressure
        m_ready = 1'b0;
        push(16'hA001);
        push(16'hA002);
        push(16'hA003);
        cyc();
        cyc();
        cyc();
        chk("bp_left", {26'b0, wp - rp}, 32'd1);
        chk("bp_head", {16'b0, fifo_rd_data}, 32'h0000A003);
        chk("bp_rden", {31'b0, fifo_rd_en}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            chk("bp_hold", {16'b0, m_data}, 32'h0000A001);
            chk("bp_valid", {31'b0, m_valid}, 32'd1);
            cyc();
        end
        m_ready = 1'b1;
        repeat (4) cyc();
        chk("bp_drained", exp_q.size(), 32'd0);
        chk("bp_cnt", {16'b0, word_count}, 32'd11);

        // sparse
        push(16'hBEEF);
        cyc();
        chk("sparse_valid", {31'b0, m_valid}, 32'd1);
        chk("sparse_data", {16'b0, m_data}, 32'h0000BEEF);
        cyc();
        chk("sparse_drop", {31'b0, m_valid}, 32'd0);
        repeat (3) cyc();
        chk("sparse_cnt", {16'b0, word_count}, 32'd12);

        // flush
        m_ready = 1'b0;
        push(16'hC001);
        push(16'hC002);
        push(16'hC003);
        push(16'hC004);
        repeat (3) cyc();
        chk("fl_pre_valid", {31'b0, m_valid}, 32'd1);
        flush = 1'b1;
        #1;
        chk("fl_rden", {31'b0, fifo_rd_en}, 32'd0);
        cyc();
        flush = 1'b0;
        chk("fl_valid", {31'b0, m_valid}, 32'd0);
        chk("fl_cnt", {16'b0, word_count}, 32'd12);
        chk("fl_head", {16'b0, fifo_rd_data}, 32'h0000C003);
        chk("fl_left", {26'b0, wp - rp}, 32'd2);
        exp_q.delete();
        exp_q.push_back(16'hC003);
        exp_q.push_back(16'hC004);
        m_ready = 1'b1;
        repeat (5) cyc();
        chk("fl_drained", exp_q.size(), 32'd0);
        chk("fl_cnt2", {16'b0, word_count}, 32'd14);

        // counter wrap on the 4-bit instance
        do_reset(2);
        m_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            push(16'(16'h0100 + i));
            cyc();
        end
        repeat (3) cyc();
        chk("wrap_drained", exp_q.size(), 32'd0);
        chk("wrap_cnt4", {28'b0, word_count4}, 32'd1);
        chk("wrap_cnt16", {16'b0, word_count}, 32'd17);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
